// File: rtl/pp_pkg.sv
// Shared types for the rdy/ack protocol checker: error codes, channel FSM states, select width.
// Latency: n/a. Backpressure: n/a.
// Optional build macro used by the checker: PP_STALL_STAT_EN.
package pp_pkg;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_DROP       = 3'd1;
  localparam logic [2:0] ERR_DATA_CHG   = 3'd2;
  localparam logic [2:0] ERR_ACK_NO_RDY = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } pp_state_e;

  function automatic int pp_chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pp_check_ch.sv
// One monitored channel: FSM, held data, stall watchdog, transfer counter; stall stats under PP_STALL_STAT_EN.
// Latency: err_pulse/err_code are combinational on current inputs; counters update at the edge.
// Backpressure: none, passive observer of rdy/ack.
module pp_check_ch import pp_pkg::*; #(
  parameter int BW      = 8,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          ack,
  input  logic [BW-1:0] dat,
  input  logic          clr,
  output logic          err_pulse,
  output logic [2:0]    err_code,
  output logic [BW-1:0] held,
  output logic [CW-1:0] xfer_cnt,
  output logic [CW-1:0] stall_max
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_HIT  = CW'(TIMEOUT - 1);

  pp_state_e     state_q, state_d;
  logic [CW-1:0] stall_q, stall_d, xfer_d;
  logic          in_stall, stay;
  logic          e_drop, e_chg, e_anr, e_to;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rdy && !ack) state_d = STALL;
      STALL:   if (!rdy || ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_stall = (state_q == STALL);
  assign stay     = in_stall && (state_d == STALL);

  // Case inequality so that X/Z on a held bus is reported as a change.
  assign e_drop = in_stall && !rdy;
  assign e_chg  = in_stall && rdy && (dat !== held);
  assign e_anr  = ack && !rdy;
  assign e_to   = (TIMEOUT != 0) && in_stall && (stall_q == TO_HIT);

  always_comb begin
    err_code = ERR_NONE;
    if      (e_drop) err_code = ERR_DROP;
    else if (e_chg)  err_code = ERR_DATA_CHG;
    else if (e_anr)  err_code = ERR_ACK_NO_RDY;
    else if (e_to)   err_code = ERR_TIMEOUT;
  end

  assign err_pulse = (err_code != ERR_NONE);

  // Saturating at TIMEOUT keeps the watchdog from re-firing within one episode.
  always_comb begin
    stall_d = '0;
    if ((TIMEOUT != 0) && stay)
      stall_d = (stall_q == TO_LIM) ? stall_q : stall_q + CW'(1);
  end

  always_comb begin
    xfer_d = clr ? '0 : xfer_cnt;
    if (rdy && ack && (xfer_d != CNT_MAX))
      xfer_d = xfer_d + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stall_q  <= '0;
      xfer_cnt <= '0;
      held     <= '0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      xfer_cnt <= xfer_d;
      if (!in_stall && (state_d == STALL))
        held <= dat;
    end
  end

`ifdef PP_STALL_STAT_EN
  logic [CW-1:0] len_q, len_inc, max_d;

  assign len_inc = (len_q == CNT_MAX) ? len_q : len_q + CW'(1);

  always_comb begin
    max_d = clr ? '0 : stall_max;
    if (in_stall && (state_d != STALL) && (len_inc > max_d))
      max_d = len_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      stall_max <= '0;
    end else begin
      len_q     <= stay ? len_inc : '0;
      stall_max <= max_d;
    end
  end
`else
  assign stall_max = '0;
`endif

endmodule

// File: rtl/pp_check_multi.sv
// NCH-channel rdy/ack checker: sticky error flags, first-error capture, per-channel readout (PP_STALL_STAT_EN adds stall stats).
// Latency: violation before edge n shows in err_vec after edge n; readout follows sel by one edge.
// Backpressure: none, never drives the monitored protocol.
module pp_check_multi import pp_pkg::*; #(
  parameter  int NCH     = 4,
  parameter  int BW      = 8,
  parameter  int TIMEOUT = 1024,
  parameter  int CW      = 16,
  localparam int CHW     = pp_chw(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    rdy,
  input  logic [NCH-1:0]    ack,
  input  logic [NCH*BW-1:0] dat,
  input  logic              clr,
  input  logic [CHW-1:0]    sel,
  output logic              err_any,
  output logic [NCH-1:0]    err_vec,
  output logic [CHW-1:0]    first_ch,
  output logic [2:0]        first_code,
  output logic [CW-1:0]     xfer_cnt,
  output logic [CW-1:0]     stall_max
);

  logic [NCH-1:0] pulse;
  logic [2:0]     code [NCH];
  logic [BW-1:0]  held [NCH];
  logic [CW-1:0]  xcnt [NCH];
  logic [CW-1:0]  smax [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pp_check_ch #(.BW(BW), .TIMEOUT(TIMEOUT), .CW(CW)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .rdy       (rdy[i]),
      .ack       (ack[i]),
      .dat       (dat[i*BW +: BW]),
      .clr       (clr),
      .err_pulse (pulse[i]),
      .err_code  (code[i]),
      .held      (held[i]),
      .xfer_cnt  (xcnt[i]),
      .stall_max (smax[i])
    );
  end

  logic           first_vld, cap;
  logic [CHW-1:0] win_ch;
  logic [2:0]     win_code;

  // Scan from the top so the lowest erring channel is the one left standing.
  always_comb begin
    win_ch   = '0;
    win_code = ERR_NONE;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pulse[i]) begin
        win_ch   = CHW'(i);
        win_code = code[i];
      end
    end
  end

  assign cap = (clr || !first_vld) && (|pulse);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vec    <= '0;
      first_vld  <= 1'b0;
      first_ch   <= '0;
      first_code <= ERR_NONE;
      xfer_cnt   <= '0;
      stall_max  <= '0;
    end else begin
      err_vec <= (clr ? '0 : err_vec) | pulse;
      if (clr) begin
        first_vld  <= 1'b0;
        first_ch   <= '0;
        first_code <= ERR_NONE;
      end
      if (cap) begin
        first_vld  <= 1'b1;
        first_ch   <= win_ch;
        first_code <= win_code;
      end
      if (clr || (int'(sel) >= NCH)) begin
        xfer_cnt  <= '0;
        stall_max <= '0;
      end else begin
        xfer_cnt  <= xcnt[sel];
        stall_max <= smax[sel];
      end
    end
  end

  assign err_any = |err_vec;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && cap)
      $display("%m: first protocol error ch=%0d code=%0d held=0x%h dat=0x%h",
               win_ch, win_code, held[win_ch], dat[win_ch*BW +: BW]);
  end
`endif

endmodule

// File: tb/tb_pp_check_multi.sv
// Bench for pp_check_multi (NCH=4, BW=8, TIMEOUT=8, CW=16); honours PP_STALL_STAT_EN.
// Reference model tracks each channel as "stalled or not" plus run lengths, in plain integers.
module tb_pp_check_multi;
  localparam int NCH = 4, BW = 8, TIMEOUT = 8, CW = 16;

  logic              clk, rst_n, clr;
  logic [NCH-1:0]    rdy, ack;
  logic [NCH*BW-1:0] dat;
  logic [1:0]        sel;
  logic              err_any;
  logic [NCH-1:0]    err_vec;
  logic [1:0]        first_ch;
  logic [2:0]        first_code;
  logic [CW-1:0]     xfer_cnt, stall_max;

  int checks = 0;
  int errors = 0;

  pp_check_multi #(.NCH(NCH), .BW(BW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .ack(ack), .dat(dat), .clr(clr), .sel(sel),
    .err_any(err_any), .err_vec(err_vec), .first_ch(first_ch), .first_code(first_code),
    .xfer_cnt(xfer_cnt), .stall_max(stall_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit             m_st   [NCH];
  logic [BW-1:0]  m_held [NCH];
  int             m_run  [NCH];
  int             m_xfer [NCH];
  int             m_max  [NCH];
  logic [NCH-1:0] m_err;
  bit             m_fv;
  logic [1:0]     m_fch;
  logic [2:0]     m_fcode;
  logic [15:0]    m_xout, m_sout;
  logic [BW-1:0]  cur    [NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = 0; m_held[i] = '0; m_run[i] = 0; m_xfer[i] = 0; m_max[i] = 0;
    end
    m_err = '0; m_fv = 0; m_fch = '0; m_fcode = '0; m_xout = '0; m_sout = '0;
  endtask

  // Applies the protocol rules to the inputs about to be sampled at the next edge.
  task automatic model_step();
    int code [NCH];
    logic [NCH-1:0] hit;
    m_xout = clr ? 16'd0 : 16'(m_xfer[sel]);
`ifdef PP_STALL_STAT_EN
    m_sout = clr ? 16'd0 : 16'(m_max[sel]);
`else
    m_sout = 16'd0;
`endif
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      logic r, a;
      logic [BW-1:0] d;
      r = rdy[i]; a = ack[i]; d = dat[i*BW +: BW];
      code[i] = 0;
      if (m_st[i] && (m_run[i] + 1 == TIMEOUT)) code[i] = 4;
      if (a && !r) code[i] = 3;
      if (m_st[i] && r && (d !== m_held[i])) code[i] = 2;
      if (m_st[i] && !r) code[i] = 1;
      hit[i] = (code[i] != 0);
    end
    if (clr) begin m_err = '0; m_fv = 0; m_fch = '0; m_fcode = '0; end
    m_err = m_err | hit;
    if (!m_fv && (hit != '0)) begin
      m_fv = 1;
      for (int i = NCH - 1; i >= 0; i--)
        if (hit[i]) begin m_fch = 2'(i); m_fcode = 3'(code[i]); end
    end
    for (int i = 0; i < NCH; i++) begin
      logic r, a;
      logic [BW-1:0] d;
      r = rdy[i]; a = ack[i]; d = dat[i*BW +: BW];
      if (clr) begin m_xfer[i] = 0; m_max[i] = 0; end
      if (r && a && (m_xfer[i] < 65535)) m_xfer[i]++;
      if (m_st[i]) begin
        if (!r || a) begin
          if (m_run[i] + 1 > m_max[i]) m_max[i] = m_run[i] + 1;
          m_st[i] = 0; m_run[i] = 0;
        end else begin
          m_run[i]++;
        end
      end else if (r && !a) begin
        m_st[i] = 1; m_held[i] = d; m_run[i] = 0;
      end
    end
  endtask

  task automatic cycle(int n = 1);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(int ch, logic r, logic a, logic [7:0] d);
    rdy[ch] = r; ack[ch] = a; dat[ch*BW +: BW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; rdy = '0; ack = '0; dat = '0; sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_vec !== 4'b0000) begin errors++; $display("FAIL reset_err_vec got=%b exp=0000", err_vec); end
    checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL reset_err_any got=%b exp=0", err_any); end
    checks++; if (first_ch !== 2'd0) begin errors++; $display("FAIL reset_first_ch got=%0d exp=0", first_ch); end
    checks++; if (first_code !== 3'd0) begin errors++; $display("FAIL reset_first_code got=%0d exp=0", first_code); end
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
    checks++; if (stall_max !== 16'd0) begin errors++; $display("FAIL reset_stall_max got=%0d exp=0", stall_max); end
    rst_n = 1'b1;
  endtask

  task automatic test_transfer();
    sel = 2'd0;
    drive(0, 1, 0, 8'h5A); cycle(3);
    drive(0, 1, 1, 8'h5A); cycle();
    drive(0, 0, 0, 8'h00); cycle();
    checks++; if (err_vec !== 4'b0000) begin errors++; $display("FAIL xfer_no_err got=%b exp=0000", err_vec); end
    checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL xfer_cnt_one got=%0d exp=1", xfer_cnt); end
    checks++; if (xfer_cnt !== m_xout) begin errors++; $display("FAIL xfer_cnt_model got=%0d exp=%0d", xfer_cnt, m_xout); end
  endtask

  task automatic test_data_chg();
    drive(1, 1, 0, 8'h11); cycle();
    drive(1, 1, 0, 8'h12); cycle();
    checks++; if (err_vec !== 4'b0010) begin errors++; $display("FAIL chg_err_vec got=%b exp=0010", err_vec); end
    checks++; if (first_ch !== 2'd1) begin errors++; $display("FAIL chg_first_ch got=%0d exp=1", first_ch); end
    checks++; if (first_code !== 3'd2) begin errors++; $display("FAIL chg_first_code got=%0d exp=2", first_code); end
    checks++; if (err_any !== 1'b1) begin errors++; $display("FAIL chg_err_any got=%b exp=1", err_any); end
    drive(1, 1, 1, 8'h12); cycle();
    drive(1, 0, 0, 8'h00); cycle();
  endtask

  task automatic test_drop_vs_chg();
    clr = 1'b1; cycle(); clr = 1'b0;
    drive(2, 1, 0, 8'hA2); drive(3, 1, 0, 8'hA3); cycle();
    drive(2, 0, 0, 8'hA2); drive(3, 1, 0, 8'hC3); cycle();
    checks++; if (err_vec !== 4'b1100) begin errors++; $display("FAIL same_cycle_err_vec got=%b exp=1100", err_vec); end
    checks++; if (first_ch !== 2'd2) begin errors++; $display("FAIL same_cycle_first_ch got=%0d exp=2", first_ch); end
    checks++; if (first_code !== 3'd1) begin errors++; $display("FAIL same_cycle_first_code got=%0d exp=1", first_code); end
    drive(3, 1, 1, 8'hC3); cycle();
    drive(2, 0, 0, 8'h00); drive(3, 0, 0, 8'h00); cycle();
  endtask

  task automatic test_ack_no_rdy_timeout();
    logic exp;
    clr = 1'b1; cycle(); clr = 1'b0;
    drive(0, 0, 1, 8'h00); cycle();
    drive(0, 0, 0, 8'h00);
    checks++; if (err_vec !== 4'b0001) begin errors++; $display("FAIL anr_err_vec got=%b exp=0001", err_vec); end
    checks++; if (first_code !== 3'd3) begin errors++; $display("FAIL anr_first_code got=%0d exp=3", first_code); end
    // Call 1 enters STALL; calls 2.. are stall cycles 1..; the 8th one is call 9.
    for (int k = 1; k <= 20; k++) begin
      drive(3, 1, 0, 8'h77);
      clr = (k == 15);
      cycle();
      clr = 1'b0;
      exp = (k >= 9) && (k < 15);
      checks++; if (err_vec[3] !== exp) begin errors++; $display("FAIL timeout_k%0d got=%b exp=%b", k, err_vec[3], exp); end
      if (k == 9) begin
        checks++; if (first_code !== 3'd3) begin errors++; $display("FAIL timeout_first_frozen got=%0d exp=3", first_code); end
      end
    end
    checks++; if (err_vec !== 4'b0000) begin errors++; $display("FAIL timeout_no_refire got=%b exp=0000", err_vec); end
    drive(3, 1, 1, 8'h77); cycle();
    drive(3, 0, 0, 8'h00); cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < NCH; i++) cur[i] = 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(7) == 0) cur[i] = 8'($urandom);
        if (i == 3) drive(i, $urandom_range(31) != 0, $urandom_range(15) == 0, cur[i]);
        else        drive(i, $urandom_range(3) != 0, $urandom_range(2) == 0, cur[i]);
      end
      clr = ($urandom_range(15) == 0);
      sel = 2'($urandom_range(3));
      cycle();
      checks++; if (err_vec !== m_err) begin errors++; $display("FAIL rnd_err_vec c=%0d got=%b exp=%b", c, err_vec, m_err); end
      checks++; if (err_any !== (|m_err)) begin errors++; $display("FAIL rnd_err_any c=%0d got=%b exp=%b", c, err_any, |m_err); end
      checks++; if (first_ch !== m_fch) begin errors++; $display("FAIL rnd_first_ch c=%0d got=%0d exp=%0d", c, first_ch, m_fch); end
      checks++; if (first_code !== m_fcode) begin errors++; $display("FAIL rnd_first_code c=%0d got=%0d exp=%0d", c, first_code, m_fcode); end
      checks++; if (xfer_cnt !== m_xout) begin errors++; $display("FAIL rnd_xfer_cnt c=%0d got=%0d exp=%0d", c, xfer_cnt, m_xout); end
      checks++; if (stall_max !== m_sout) begin errors++; $display("FAIL rnd_stall_max c=%0d got=%0d exp=%0d", c, stall_max, m_sout); end
    end
    clr = 1'b0; rdy = '0; ack = '0; cycle(2);
  endtask

  task automatic test_saturation();
    sel = 2'd0;
    clr = 1'b1; drive(2, 0, 1, 8'h00); cycle();
    clr = 1'b0; drive(2, 0, 0, 8'h00);
    checks++; if (err_vec !== 4'b0100) begin errors++; $display("FAIL clr_cycle_err_vec got=%b exp=0100", err_vec); end
    checks++; if (first_ch !== 2'd2) begin errors++; $display("FAIL clr_cycle_first_ch got=%0d exp=2", first_ch); end
    checks++; if (first_code !== 3'd3) begin errors++; $display("FAIL clr_cycle_first_code got=%0d exp=3", first_code); end
    drive(0, 1, 1, 8'h3C);
    cycle(70000);
    drive(0, 0, 0, 8'h00); cycle(2);
    checks++; if (xfer_cnt !== 16'hFFFF) begin errors++; $display("FAIL xfer_saturate got=%0d exp=65535", xfer_cnt); end
    checks++; if (err_vec !== 4'b0100) begin errors++; $display("FAIL xfer_saturate_err got=%b exp=0100", err_vec); end
  endtask

  task automatic test_reset_mid_stall();
    sel = 2'd1;
    drive(1, 1, 0, 8'h44); cycle(3);
    rst_n = 1'b0;
    #1;
    checks++; if (err_vec !== 4'b0000) begin errors++; $display("FAIL midrst_err_vec got=%b exp=0000", err_vec); end
    checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL midrst_err_any got=%b exp=0", err_any); end
    checks++; if (first_code !== 3'd0) begin errors++; $display("FAIL midrst_first_code got=%0d exp=0", first_code); end
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL midrst_xfer_cnt got=%0d exp=0", xfer_cnt); end
    rdy = '0; ack = '0; dat = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(3);
    checks++; if (err_vec !== 4'b0000) begin errors++; $display("FAIL release_err_vec got=%b exp=0000", err_vec); end
    checks++; if (first_ch !== 2'd0) begin errors++; $display("FAIL release_first_ch got=%0d exp=0", first_ch); end
  endtask

  task automatic test_stall_stat();
    logic [15:0] exp;
`ifdef PP_STALL_STAT_EN
    exp = 16'd5;
`else
    exp = 16'd0;
`endif
    sel = 2'd1;
    drive(1, 1, 0, 8'h21); cycle(3);
    drive(1, 1, 1, 8'h21); cycle();
    drive(1, 0, 0, 8'h00); cycle();
    drive(1, 1, 0, 8'h22); cycle(5);
    drive(1, 1, 1, 8'h22); cycle();
    drive(1, 0, 0, 8'h00); cycle(2);
    checks++; if (stall_max !== exp) begin errors++; $display("FAIL stall_max got=%0d exp=%0d", stall_max, exp); end
    checks++; if (stall_max !== m_sout) begin errors++; $display("FAIL stall_max_model got=%0d exp=%0d", stall_max, m_sout); end
    checks++; if (err_vec !== 4'b0000) begin errors++; $display("FAIL stall_stat_err got=%b exp=0000", err_vec); end
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_data_chg();
    test_drop_vs_chg();
    test_ack_no_rdy_timeout();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    test_stall_stat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pp_check_multi.md
Name: pp_check_multi

Overview:
Multi-channel, parametrised checker for the rdy/ack pipeline protocol. It generalises the single-channel keep-while-stalled check to NCH channels and adds four things: an ack-without-rdy check, a stall-timeout watchdog, saturating per-channel transfer counters, and first-error capture. It is a passive bench monitor placed alongside any DUT port group; it never drives the protocol signals.

Parameters:
NCH, 4, number of monitored channels (1..16)
BW, 8, data width per channel, excluding rdy
TIMEOUT, 1024, consecutive stall cycles that raise a timeout error; 0 disables the watchdog
CW, 16, width of transfer and stall counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rdy  in  NCH  per-channel ready (data valid)
ack  in  NCH  per-channel acknowledge
dat  in  NCH*BW  channel i data at dat[i*BW +: BW]
clr  in  1  synchronous clear of errors and counters
sel  in  CHW  channel select for readout; CHW = max(1, clog2(NCH))
err_any  out  1  OR of err_vec
err_vec  out  NCH  sticky per-channel error flags
first_ch  out  CHW  channel of the first recorded error
first_code  out  3  code of the first recorded error
xfer_cnt  out  CW  registered transfer count of channel sel
stall_max  out  CW  longest stall of channel sel; 0 when feature is off

Behaviour:
- Reset: every output 0, all per-channel state IDLE, all counters 0, first-capture disarmed.
- Transfer: rdy[i] & ack[i] at a rising edge.
- Per-channel FSM:
  - IDLE -> STALL when rdy=1 & ack=0.
  - STALL -> IDLE on rdy & ack, or when rdy drops.
  - STALL holds the sampled dat.
- Error codes, evaluated each edge on current inputs:
  - 1 DROP: in STALL and rdy=0.
  - 2 DATA_CHG: in STALL, rdy=1, and dat differs from the held value (case inequality, so X/Z counts as a change).
  - 3 ACK_NO_RDY: ack=1 with rdy=0, in any state.
  - 4 TIMEOUT: stall counter reaches TIMEOUT. Fires once per stall episode; the counter saturates and does not re-fire.
  - Several codes on one channel in the same cycle: the lowest code is reported.
- Latency: a violation present in the cycle before edge n sets err_vec at edge n, visible the following cycle. err_any is combinational from err_vec.
- first_ch/first_code: captured on the first error after reset or clr, then frozen. If several channels err in the same cycle, the lowest index wins.
- Checking continues after any error. err_vec bits only set; they never clear except by reset or clr.
- Stall counter: counts cycles in STALL, resets to 0 on leaving STALL, saturates at TIMEOUT.
- Transfer counter: +1 per transfer, saturates at 2^CW-1.
- xfer_cnt/stall_max: sel is sampled at the edge; the value of the selected channel appears the next cycle.
- clr:
  - Zeroes err_vec, first_*, transfer counters and stall_max, and re-arms first-capture.
  - Does not alter FSM state or held data, so an in-progress stall is still checked.
  - An error detected in the clr cycle is recorded after the clear: it appears in err_vec and first_*.
- Reset mid-stall: all state returns to IDLE. No error is reported on release unless a new violation occurs.
- Simulation builds only: on the first error, $display the channel, code, held data and current data via %m. Never $finish; the bench decides.

Optional Feature:
PP_STALL_STAT_EN
- Defined: each channel keeps a stall-length counter (saturating at 2^CW-1, independent of TIMEOUT) and a running maximum. stall_max reports the maximum for channel sel; it updates when a stall ends and is cleared by clr.
- Undefined: no stall-statistics logic; stall_max is tied to 0. The port exists in both builds.

Decomposition:
- Package pp_pkg:
  - error-code localparams ERR_NONE=0, ERR_DROP=1, ERR_DATA_CHG=2, ERR_ACK_NO_RDY=3, ERR_TIMEOUT=4
  - FSM state encoding IDLE/STALL
  - CHW width function
- Sub-module pp_check_ch: one channel's FSM, held data, stall counter, transfer counter, optional stall max; outputs err_pulse and err_code. Instantiated NCH times in a generate loop.
- Top level: sticky flags, first-error arbitration and the sel readout mux.

Test Plan:
Bench configuration for all tests: NCH=4, BW=8, TIMEOUT=8, CW=16.
1. ch0: rdy=1, dat=0x5A, ack=0 for 3 cycles, then ack=1 -> no error; xfer_cnt=1 one cycle after sel=0.
2. ch1 stalled with dat=0x11, next cycle dat=0x12 -> err_vec=0010, first_ch=1, first_code=2, err_any=1.
3. ch2 drops rdy while stalled in the same cycle ch3 changes data while stalled -> err_vec=1100, first_ch=2, first_code=1.
4. ch0: ack=1 with rdy=0 -> code 3. Then ch3 stalls 20 cycles -> timeout fires once at the 8th stall cycle; err_vec[3] stays set.
5. clr pulse, then 70000 back-to-back transfers on ch0 -> xfer_cnt=65535, saturated. Error injected in the clr cycle -> recorded.
6. Assert rst_n low mid-stall on ch1, release with rdy=0 -> all outputs 0, no error. With PP_STALL_STAT_EN, stalls of 3 and 5 cycles -> stall_max=5.
